// File: rtl/schoolbook_pkg.sv
// Shared types and helpers for the digit-serial schoolbook multiplier.
// Carry-less support in the datapath is enabled with SCHOOLBOOK_GF2_EN.
package schoolbook_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_INT   = 1'b0;
  localparam logic MODE_CLMUL = 1'b1;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/schoolbook_digit_pp.sv
// Combinational WIDTH_A x DIGIT partial product; the carry-less variant
// exists only when SCHOOLBOOK_GF2_EN is defined.
module schoolbook_digit_pp
  import schoolbook_pkg::*;
#(
  parameter int WIDTH_A = 571,
  parameter int DIGIT   = 8
) (
  input  logic [WIDTH_A-1:0]       a,
  input  logic [DIGIT-1:0]         d,
`ifdef SCHOOLBOOK_GF2_EN
  input  logic                     mode,
`endif
  output logic [WIDTH_A+DIGIT-1:0] pp
);

  localparam int PPW = WIDTH_A + DIGIT;

  logic [PPW-1:0] a_ext;
  logic [PPW-1:0] d_ext;
  logic [PPW-1:0] pp_int;

  assign a_ext  = PPW'(a);
  assign d_ext  = PPW'(d);
  assign pp_int = a_ext * d_ext;

`ifdef SCHOOLBOOK_GF2_EN
  logic [PPW-1:0] pp_clmul;

  // GF(2)[x] product: XOR of shifted copies of a, no carries between columns
  always_comb begin
    pp_clmul = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (d[i]) begin
        pp_clmul = pp_clmul ^ (a_ext << i);
      end
    end
  end

  assign pp = (mode == MODE_CLMUL) ? pp_clmul : pp_int;
`else
  assign pp = pp_int;
`endif

endmodule

// File: rtl/schoolbook_ds.sv
// Digit-serial schoolbook multiplier with start/busy/done handshake.
// Defining SCHOOLBOOK_GF2_EN adds the mode port and carry-less multiply.
module schoolbook_ds
  import schoolbook_pkg::*;
#(
  parameter int WIDTH_A = 571,
  parameter int WIDTH_B = 571,
  parameter int DIGIT   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
`ifdef SCHOOLBOOK_GF2_EN
  input  logic                       mode,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH_A+WIDTH_B-1:0] c
);

  localparam int N   = ceil_div(WIDTH_B, DIGIT);
  localparam int CW  = $clog2(N + 1);
  localparam int BW  = N * DIGIT;
  localparam int PW  = WIDTH_A + WIDTH_B;
  localparam int PPW = WIDTH_A + DIGIT;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e            state_q, state_d;
  logic [WIDTH_A-1:0] a_q, a_d;
  logic [BW-1:0]     b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
`ifdef SCHOOLBOOK_GF2_EN
  logic              mode_q, mode_d;
`endif

  logic [DIGIT-1:0]  digit;
  logic [PPW-1:0]    pp;
  logic [PW-1:0]     pp_ext;
  logic [PW-1:0]     pp_sh;
  int                shamt;

  // Constant-index mux keeps every latched bit of b observable
  always_comb begin
    digit = '0;
    for (int i = 0; i < N; i++) begin
      if (count_q == CW'(i)) begin
        digit = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  schoolbook_digit_pp #(
    .WIDTH_A (WIDTH_A),
    .DIGIT   (DIGIT)
  ) u_digit_pp (
    .a    (a_q),
    .d    (digit),
`ifdef SCHOOLBOOK_GF2_EN
    .mode (mode_q),
`endif
    .pp   (pp)
  );

  always_comb begin
    pp_ext          = '0;
    pp_ext[PPW-1:0] = pp;
    shamt           = int'(count_q) * DIGIT;
    pp_sh           = pp_ext << shamt;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    count_d = count_q;
`ifdef SCHOOLBOOK_GF2_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = BW'(b);
          acc_d   = '0;
          count_d = '0;
`ifdef SCHOOLBOOK_GF2_EN
          mode_d  = mode;
`endif
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Zero digits still take their cycle so latency never depends on data
`ifdef SCHOOLBOOK_GF2_EN
        if (mode_q == MODE_CLMUL) begin
          acc_d = acc_q ^ pp_sh;
        end else begin
          acc_d = acc_q + pp_sh;
        end
`else
        acc_d = acc_q + pp_sh;
`endif
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
`ifdef SCHOOLBOOK_GF2_EN
      mode_q  <= MODE_INT;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
`ifdef SCHOOLBOOK_GF2_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign c    = acc_q;

endmodule

// File: tb/tb_schoolbook_ds.sv
// Directed bench for schoolbook_ds: a small 8x8/digit-3 instance and a
// default 571x571/digit-8 instance; carry-less tests need SCHOOLBOOK_GF2_EN.
module tb_schoolbook_ds;

  logic          clk;
  logic          rst;

  logic          start_s;
  logic [7:0]    a_s;
  logic [7:0]    b_s;
  logic          busy_s;
  logic          done_s;
  logic [15:0]   c_s;

  logic          start_l;
  logic [570:0]  a_l;
  logic [570:0]  b_l;
  logic          busy_l;
  logic          done_l;
  logic [1141:0] c_l;

`ifdef SCHOOLBOOK_GF2_EN
  logic          mode_s;
  logic          mode_l;
`endif

  int checks;
  int errors;

  schoolbook_ds #(.WIDTH_A(8), .WIDTH_B(8), .DIGIT(3)) dut_s (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .a     (a_s),
    .b     (b_s),
`ifdef SCHOOLBOOK_GF2_EN
    .mode  (mode_s),
`endif
    .busy  (busy_s),
    .done  (done_s),
    .c     (c_s)
  );

  schoolbook_ds #(.WIDTH_A(571), .WIDTH_B(571), .DIGIT(8)) dut_l (
    .clk   (clk),
    .rst   (rst),
    .start (start_l),
    .a     (a_l),
    .b     (b_l),
`ifdef SCHOOLBOOK_GF2_EN
    .mode  (mode_l),
`endif
    .busy  (busy_l),
    .done  (done_l),
    .c     (c_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge, then settle so outputs are sampled away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || c_s !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_small busy=%b done=%b c=%h, want 0 0 0000", busy_s, done_s, c_s);
    end
    checks++;
    if (busy_l !== 1'b0 || done_l !== 1'b0 || c_l !== '0) begin
      errors++;
      $display("[TB] FAIL reset_large busy=%b done=%b c_nonzero=%b, want 0 0 0", busy_l, done_l, |c_l);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_int_ff();
    int cyc;
    int busy_cnt;
    a_s = 8'hFF;
    b_s = 8'hFF;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cyc = 1;
    busy_cnt = busy_s ? 1 : 0;
    while (!done_s && cyc < 20) begin
      tick();
      cyc++;
      if (busy_s) busy_cnt++;
    end
    checks++;
    if (cyc !== 4 || done_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL int_ff_latency edges=%0d done=%b, want 4 1", cyc, done_s);
    end
    checks++;
    if (busy_cnt !== 3) begin
      errors++;
      $display("[TB] FAIL int_ff_busy cycles=%0d, want 3", busy_cnt);
    end
    checks++;
    if (c_s !== 16'hFE01) begin
      errors++;
      $display("[TB] FAIL int_ff_product c=%h, want fe01", c_s);
    end
    tick();
    checks++;
    if (done_s !== 1'b0 || busy_s !== 1'b0 || c_s !== 16'hFE01) begin
      errors++;
      $display("[TB] FAIL int_ff_after done=%b busy=%b c=%h, want 0 0 fe01", done_s, busy_s, c_s);
    end
  endtask

`ifdef SCHOOLBOOK_GF2_EN
  task automatic test_clmul();
    int cyc;
    logic [15:0] exp_c [2];
    logic [7:0]  op [2];
    op[0] = 8'h03; exp_c[0] = 16'h0005;
    op[1] = 8'hFF; exp_c[1] = 16'h5555;
    for (int t = 0; t < 2; t++) begin
      a_s = op[t];
      b_s = op[t];
      mode_s = 1'b1;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      mode_s = 1'b0;
      cyc = 1;
      while (!done_s && cyc < 20) begin
        tick();
        cyc++;
      end
      checks++;
      if (cyc !== 4 || c_s !== exp_c[t]) begin
        errors++;
        $display("[TB] FAIL clmul_%0d edges=%0d c=%h, want 4 %h", t, cyc, c_s, exp_c[t]);
      end
      tick();
    end
  endtask
`endif

  task automatic test_large();
    int cyc;
    logic [1141:0] exp_c;
    exp_c = ({1142{1'b1}} << 572) + 1142'd1;
    a_l = '1;
    b_l = '1;
    start_l = 1'b1;
    tick();
    start_l = 1'b0;
    cyc = 1;
    while (!done_l && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 73 || done_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL large_latency edges=%0d done=%b, want 73 1", cyc, done_l);
    end
    checks++;
    if (c_l !== exp_c) begin
      errors++;
      $display("[TB] FAIL large_product c_hi=%h c_lo=%h, want hi=%h lo=%h",
               c_l[1141:1078], c_l[63:0], exp_c[1141:1078], exp_c[63:0]);
    end
    tick();
  endtask

  task automatic test_mid_start();
    int cyc;
    a_s = 8'h12;
    b_s = 8'h34;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cyc = 1;
    tick();
    cyc++;
    a_s = 8'hFF;
    b_s = 8'hFF;
    start_s = 1'b1;
    tick();
    cyc++;
    start_s = 1'b0;
    while (!done_s && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 4 || c_s !== 16'h03A8) begin
      errors++;
      $display("[TB] FAIL mid_start edges=%0d c=%h, want 4 03a8", cyc, c_s);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    a_s = 8'd3;
    b_s = 8'd3;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cyc = 1;
    while (!done_s && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 4 || c_s !== 16'd9) begin
      errors++;
      $display("[TB] FAIL b2b_first edges=%0d c=%0d, want 4 9", cyc, c_s);
    end
    a_s = 8'd5;
    b_s = 8'd7;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    checks++;
    if (busy_s !== 1'b1 || c_s !== 16'd0) begin
      errors++;
      $display("[TB] FAIL b2b_accept busy=%b c=%0d, want 1 0", busy_s, c_s);
    end
    cyc = 1;
    while (!done_s && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 4 || c_s !== 16'd35) begin
      errors++;
      $display("[TB] FAIL b2b_second edges=%0d c=%0d, want 4 35", cyc, c_s);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    a_s = 8'hFF;
    b_s = 8'hFF;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    rst = 1'b1;
    start_s = 1'b1;
    tick();
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || c_s !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid busy=%b done=%b c=%h, want 0 0 0000", busy_s, done_s, c_s);
    end
    rst = 1'b0;
    start_s = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_s || busy_s) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet active_cycles=%0d, want 0", done_seen);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    start_s = 1'b0;
    a_s     = '0;
    b_s     = '0;
    start_l = 1'b0;
    a_l     = '0;
    b_l     = '0;
`ifdef SCHOOLBOOK_GF2_EN
    mode_s  = 1'b0;
    mode_l  = 1'b0;
`endif
    test_reset();
    test_int_ff();
`ifdef SCHOOLBOOK_GF2_EN
    test_clmul();
`endif
    test_large();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
